pll_drp_reconfig: RTL and testbench

//  Sequences dynamic reconfiguration of a PLLE2_ADV over its DRP port, all in the dclk domain.
//  - Holds PLL RST; walks an external register table doing DRP read-modify-write per entry.
//  - Releases RST, waits for LOCKED, reports done/error.
//  - Sits between the clocking block and board control logic; retunes CLKOUTn divide/phase
//    (e.g. SERDES / ODDR clocks) without a new bitstream.

---
 rtl/pll_drp_pkg.sv | 27 ++
 rtl/pll_drp_if.sv | 13 +
 rtl/lock_sync.sv | 20 ++
 rtl/pll_drp_reconfig.sv | 206 ++++++++++++++++++++
 tb/tb_pll_drp_reconfig.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLLE2_ADV DRP reconfiguration sequencer.
// state_t     : sequencer states (VF_* only reachable when PLL_DRP_VERIFY_EN is defined)
// err_t       : result code reported on err_code
// drp_entry_t : one register-table entry {addr, mask, data}
// rmw()       : merge of a read-back word with a table entry (mask bit 1 = keep)
package pll_drp_pkg;
  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_ASSERT_RST, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT,
    S_VF_REQ, S_VF_WAIT, S_NEXT, S_RELEASE, S_LOCK_WAIT, S_FINISH
  } state_t;

  typedef enum logic [1:0] {ERR_NONE, ERR_DRDY, ERR_LOCK, ERR_VERIFY} err_t;

  typedef struct packed {
    logic [DRP_AW-1:0] addr;
    logic [DRP_DW-1:0] mask;
    logic [DRP_DW-1:0] data;
  } drp_entry_t;

  function automatic logic [DRP_DW-1:0] rmw(input logic [DRP_DW-1:0] cur,
                                            input drp_entry_t e);
    return (cur & e.mask) | (e.data & ~e.mask);
  endfunction
endpackage

// File: rtl/pll_drp_if.sv
// DRP bus between the sequencer (master) and the PLLE2_ADV DRP port (slave).
// daddr/den/dwe/di : master -> PLL ; dout/drdy : PLL -> master
interface pll_drp_if;
  logic [pll_drp_pkg::DRP_AW-1:0] daddr;
  logic                           den;
  logic                           dwe;
  logic [pll_drp_pkg::DRP_DW-1:0] di;
  logic [pll_drp_pkg::DRP_DW-1:0] dout;
  logic                           drdy;

  modport master (output daddr, den, dwe, di, input dout, drdy);
  modport slave  (input daddr, den, dwe, di, output dout, drdy);
endinterface

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCKED into dclk.
// dclk/reset_n : clock, async active-low clear
// async_in     : raw LOCKED ; sync_out : synchronized LOCKED
module lock_sync (
  input  logic dclk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb sync_d = {sync_q[0], async_in};

  always_ff @(posedge dclk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;

  assign sync_out = sync_q[1];
endmodule

// File: rtl/pll_drp_reconfig.sv
// PLLE2_ADV dynamic reconfiguration sequencer (dclk domain only).
// Holds PLL RST, walks the external register table doing DRP read-modify-write
// per entry, releases RST, waits for LOCKED and reports done/err_code.
// Ports: dclk/reset_n clock and async active-low reset; start/busy/done/err_code
// run control; tbl_idx out selects the entry, tbl_addr/mask/data return it
// combinationally; drp is the DRP master bus; pll_rst/pll_locked to/from the PLL.
// Build option: define PLL_DRP_VERIFY_EN to read back and compare each write.
module pll_drp_reconfig
  import pll_drp_pkg::*;
#(
  parameter int NUM_REGS     = 8,
  parameter int IDX_W        = 6,
  parameter int RST_HOLD     = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              dclk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [DRP_AW-1:0] tbl_addr,
  input  logic [DRP_DW-1:0] tbl_mask,
  input  logic [DRP_DW-1:0] tbl_data,
  pll_drp_if.master         drp,
  output logic              pll_rst,
  input  logic              pll_locked
);
  localparam int CNT_MAX0 = (DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD;
  localparam int CNT_MAX  = (LOCK_TIMEOUT > CNT_MAX0) ? LOCK_TIMEOUT : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] DRDY_LD = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  err_t              err_q, err_d, fin_err;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d, done_q, done_d, rst_q, rst_d;
  logic              den_q, den_d, dwe_q, dwe_d;
  logic [DRP_AW-1:0] daddr_q, daddr_d;
  logic [DRP_DW-1:0] di_q, di_d;
`ifdef PLL_DRP_VERIFY_EN
  logic [DRP_DW-1:0] new_q, new_d;
`endif
  logic              fin;
  logic              locked_s;
  drp_entry_t        ent;

  lock_sync u_lock_sync (.dclk(dclk), .reset_n(reset_n), .async_in(pll_locked), .sync_out(locked_s));

  assign ent = '{addr: tbl_addr, mask: tbl_mask, data: tbl_data};

  // DRP outputs are loaded on the edge entering a *_REQ state so that den is
  // high exactly while the FSM sits in that REQ state. tbl_idx advances on the
  // edge entering NEXT, so the next entry's table lookup has settled for a full
  // cycle before NEXT launches the following read.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rst_d   = rst_q;
    den_d   = 1'b0;
    dwe_d   = 1'b0;
    daddr_d = '0;
    di_d    = '0;
`ifdef PLL_DRP_VERIFY_EN
    new_d   = new_q;
`endif
    fin     = 1'b0;
    fin_err = ERR_NONE;
    case (state_q)
      S_IDLE: if (start) begin
        busy_d  = 1'b1;
        err_d   = ERR_NONE;
        idx_d   = '0;
        rst_d   = 1'b1;
        cnt_d   = HOLD_LD;
        state_d = S_ASSERT_RST;
      end
      S_ASSERT_RST:
        if (cnt_q == '0) begin
          state_d = S_RD_REQ;
          den_d   = 1'b1;
          daddr_d = ent.addr;
        end else cnt_d = cnt_q - 1'b1;
      S_RD_REQ: begin cnt_d = DRDY_LD; state_d = S_RD_WAIT; end
      S_RD_WAIT:
        if (drp.drdy) begin
          state_d = S_WR_REQ;
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          daddr_d = ent.addr;
          di_d    = rmw(drp.dout, ent);
`ifdef PLL_DRP_VERIFY_EN
          new_d   = rmw(drp.dout, ent);
`endif
        end else if (cnt_q == '0) begin fin = 1'b1; fin_err = ERR_DRDY; end
        else cnt_d = cnt_q - 1'b1;
      S_WR_REQ: begin cnt_d = DRDY_LD; state_d = S_WR_WAIT; end
      S_WR_WAIT:
        if (drp.drdy) begin
`ifdef PLL_DRP_VERIFY_EN
          state_d = S_VF_REQ;
          den_d   = 1'b1;
          daddr_d = ent.addr;
`else
          state_d = S_NEXT;
          last_d  = (idx_q == LAST_IDX);
          if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
`endif
        end else if (cnt_q == '0) begin fin = 1'b1; fin_err = ERR_DRDY; end
        else cnt_d = cnt_q - 1'b1;
`ifdef PLL_DRP_VERIFY_EN
      S_VF_REQ: begin cnt_d = DRDY_LD; state_d = S_VF_WAIT; end
      S_VF_WAIT:
        if (drp.drdy) begin
          if (drp.dout != new_q) begin fin = 1'b1; fin_err = ERR_VERIFY; end
          else begin
            state_d = S_NEXT;
            last_d  = (idx_q == LAST_IDX);
            if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
          end
        end else if (cnt_q == '0) begin fin = 1'b1; fin_err = ERR_DRDY; end
        else cnt_d = cnt_q - 1'b1;
`endif
      S_NEXT:
        if (last_q) state_d = S_RELEASE;
        else begin
          state_d = S_RD_REQ;
          den_d   = 1'b1;
          daddr_d = ent.addr;
        end
      S_RELEASE: begin rst_d = 1'b0; cnt_d = LOCK_LD; state_d = S_LOCK_WAIT; end
      S_LOCK_WAIT:
        if (locked_s) fin = 1'b1;
        else if (cnt_q == '0) begin fin = 1'b1; fin_err = ERR_LOCK; end
        else cnt_d = cnt_q - 1'b1;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Every exit path enters FINISH the same way; errors also drop PLL RST so
    // the PLL falls back to whatever configuration it now holds.
    if (fin) begin
      state_d = S_FINISH;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      rst_d   = 1'b0;
      if (fin_err != ERR_NONE) err_d = fin_err;
    end
  end

  always_ff @(posedge dclk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rst_q   <= 1'b0;
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
      daddr_q <= '0;
      di_q    <= '0;
`ifdef PLL_DRP_VERIFY_EN
      new_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rst_q   <= rst_d;
      den_q   <= den_d;
      dwe_q   <= dwe_d;
      daddr_q <= daddr_d;
      di_q    <= di_d;
`ifdef PLL_DRP_VERIFY_EN
      new_q   <= new_d;
`endif
    end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_code  = err_q;
  assign tbl_idx   = idx_q;
  assign pll_rst   = rst_q;
  assign drp.den   = den_q;
  assign drp.dwe   = dwe_q;
  assign drp.daddr = daddr_q;
  assign drp.di    = di_q;
endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Bench for pll_drp_reconfig: behavioural PLLE2_ADV (DRP register file, random
// DRDY latency, lock delay, CLKOUT2 generator from the 0x0C divide register),
// a table-level reference model feeding a scoreboard, and a decoupled monitor.
`timescale 1ns/1ps
module tb_pll_drp_reconfig;
  import pll_drp_pkg::*;
  localparam int NUM_REGS = 2, IDX_W = 6, RST_HOLD = 4;
  localparam int DRDY_TIMEOUT = 64, LOCK_TIMEOUT = 100, LOCK_DLY = 20, VCO_NS = 5;

  logic dclk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic busy, done, pll_rst, pll_locked;
  logic [1:0] err_code;
  logic [IDX_W-1:0] tbl_idx;
  logic [6:0] tbl_addr;
  logic [15:0] tbl_mask, tbl_data;
  pll_drp_if drp();

  pll_drp_reconfig #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .RST_HOLD(RST_HOLD),
    .DRDY_TIMEOUT(DRDY_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .dclk(dclk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .err_code(err_code), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_mask(tbl_mask),
    .tbl_data(tbl_data), .drp(drp.master), .pll_rst(pll_rst), .pll_locked(pll_locked));

  always #5 dclk = ~dclk;

  logic [6:0]  t_a [NUM_REGS];
  logic [15:0] t_m [NUM_REGS];
  logic [15:0] t_d [NUM_REGS];
  assign tbl_addr = t_a[tbl_idx[0]];
  assign tbl_mask = t_m[tbl_idx[0]];
  assign tbl_data = t_d[tbl_idx[0]];

  // ---------------- PLL model ----------------
  logic [15:0] regs [128];
  logic [15:0] ref_regs [128];
  int  pend = 0, lat_max = 3, drop_at = -1, acc_cnt = 0, lcnt = 0;
  bit  corrupt = 0, force_nolock = 0, last_wr = 0;
  logic [15:0] pend_do;
  logic pllclk2;

  initial begin
    drp.drdy = 1'b0; drp.dout = '0; pll_locked = 1'b1;
    forever begin
      @(posedge dclk); #1;
      drp.drdy = 1'b0;
      if (!reset_n) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin drp.drdy = 1'b1; drp.dout = pend_do; end
      end
      if (drp.den && reset_n) begin
        acc_cnt++;
        if (acc_cnt != drop_at) begin
          if (drp.dwe) begin regs[drp.daddr] = drp.di; pend_do = '0; end
          else begin
            pend_do = regs[drp.daddr];
            if (corrupt && last_wr) pend_do[0] = ~pend_do[0];
          end
          last_wr = drp.dwe;
          pend = $urandom_range(lat_max, 1);
        end
      end
      if (pll_rst) begin pll_locked = 1'b0; lcnt = 0; end
      else if (!pll_locked && !force_nolock) begin
        lcnt++;
        if (lcnt >= LOCK_DLY) pll_locked = 1'b1;
      end
    end
  end

  // CLKOUT2: ClkReg1 at 0x0C, HIGH_TIME[11:6], LOW_TIME[5:0] in VCO periods.
  initial begin
    int hi, lo;
    pllclk2 = 1'b0;
    forever begin
      hi = int'(regs[12][11:6]); lo = int'(regs[12][5:0]);
      if (pll_locked && hi != 0 && lo != 0) begin
        pllclk2 = 1'b1; #(hi * VCO_NS);
        pllclk2 = 1'b0; #(lo * VCO_NS);
      end else #5;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {logic we; logic [6:0] addr; logic [15:0] di;} txn_t;
  txn_t       exp_q[$];
  logic [1:0] exp_err_q[$];
  int n_chk = 0, n_fail = 0, n_done = 0, n_den = 0;
  int cyc = 0, last_den_cyc = 0, done_cyc = 0, rst_fall_cyc = 0;
  logic prev_rst = 1'b0;

  always @(posedge dclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Reference: for each entry read, merge, write (optionally read back);
  // stop at the access that never gets DRDY or at a bad read-back.
  task automatic predict(input int drop, input bit nolock);
    logic [15:0] nv;
    logic [1:0] e;
    int acc;
    bit stop;
    e = 2'd0; acc = 0; stop = 0;
    for (int i = 0; i < NUM_REGS && !stop; i++) begin
      acc++; exp_q.push_back('{1'b0, t_a[i], 16'h0});
      if (acc == drop) begin e = 2'd1; stop = 1; end
      if (!stop) begin
        nv = (ref_regs[t_a[i]] & t_m[i]) | (t_d[i] & ~t_m[i]);
        acc++; exp_q.push_back('{1'b1, t_a[i], nv});
        if (acc == drop) begin e = 2'd1; stop = 1; end
        else ref_regs[t_a[i]] = nv;
      end
`ifdef PLL_DRP_VERIFY_EN
      if (!stop) begin
        acc++; exp_q.push_back('{1'b0, t_a[i], 16'h0});
        if (acc == drop) begin e = 2'd1; stop = 1; end
        else if (corrupt) begin e = 2'd3; stop = 1; end
      end
`endif
    end
    if (!stop && nolock) e = 2'd2;
    exp_err_q.push_back(e);
  endtask

  // Monitor
  initial begin
    txn_t t;
    forever begin
      @(posedge dclk); #2;
      if (reset_n) begin
        if (prev_rst && !pll_rst) rst_fall_cyc = cyc;
        prev_rst = pll_rst;
        if (drp.den) begin
          n_den++; last_den_cyc = cyc;
          chk("rst_during_den", pll_rst, 1);
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_den: actual addr %0h we %0b required no access", drp.daddr, drp.dwe);
          end else begin
            t = exp_q.pop_front();
            chk("dwe", drp.dwe, t.we);
            chk("daddr", drp.daddr, t.addr);
            chk("di", drp.di, t.di);
          end
        end else chk("bus_idle", {drp.dwe, drp.daddr, drp.di}, 0);
        if (done) begin
          n_done++; done_cyc = cyc;
          chk("busy_at_done", busy, 0);
          if (exp_err_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_done: actual done=1 required 0");
          end else chk("err_code", err_code, exp_err_q.pop_front());
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);         chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_code, 0);      chk({tag, "_idx"}, tbl_idx, 0);
    chk({tag, "_den"}, drp.den, 0);       chk({tag, "_dwe"}, drp.dwe, 0);
    chk({tag, "_daddr"}, drp.daddr, 0);   chk({tag, "_di"}, drp.di, 0);
    chk({tag, "_pll_rst"}, pll_rst, 0);
  endtask

  task automatic run_once(input string tag, input int budget);
    int d0;
    d0 = n_done; acc_cnt = 0;
    @(negedge dclk) start = 1'b1;
    @(negedge dclk) start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    for (int k = 0; k < budget && n_done == d0; k++) @(negedge dclk);
    if (n_done == d0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_done_timeout: actual no done required done within %0d cycles", tag, budget);
    end
    repeat (8) @(negedge dclk);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_rst_after"}, pll_rst, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic measure(output int per);
    realtime t0;
    int seen;
    logic prev;
    per = -1; seen = 0; t0 = 0; prev = pllclk2;
    #0.5;
    for (int s = 0; s < 400 && seen < 2; s++) begin
      #1;
      if (!prev && pllclk2) begin
        if (seen == 0) t0 = $realtime;
        else per = int'($realtime - t0);
        seen++;
      end
      prev = pllclk2;
    end
  endtask

  initial begin
    int per, n0;
    for (int i = 0; i < 128; i++) begin regs[i] = 16'($urandom); ref_regs[i] = regs[i]; end
    regs[12] = 16'h1104; ref_regs[12] = 16'h1104;
    repeat (3) @(negedge dclk);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge dclk);

    // 1: fixed table
    t_a[0] = 7'h08; t_m[0] = 16'h1000; t_d[0] = 16'h0041;
    t_a[1] = 7'h09; t_m[1] = 16'hFC00; t_d[1] = 16'h0000;
    predict(-1, 0); run_once("t1", 400);

    // 2: CLKOUT2 divide 8 -> 4
    measure(per); chk("clk2_period_div8", per, 40);
    t_a[0] = 7'h0C; t_m[0] = 16'hF000; t_d[0] = 16'h0082;
    t_a[1] = 7'h0D; t_m[1] = 16'hFFFF; t_d[1] = 16'h0000;
    predict(-1, 0); run_once("t2", 400);
    measure(per); chk("clk2_period_div4", per, 20);

    // random tables and DRDY latency
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        t_a[i] = 7'($urandom); t_m[i] = 16'($urandom); t_d[i] = 16'($urandom);
      end
      lat_max = $urandom_range(6, 1);
      predict(-1, 0); run_once("rand", 400);
    end
    lat_max = 3;

    // 3: DRDY withheld on 2nd access
    drop_at = 2; predict(2, 0); run_once("t3", 400);
    chk("drdy_timeout_latency", done_cyc - last_den_cyc, DRDY_TIMEOUT + 1);
    drop_at = -1;

    // 4: never locks
    force_nolock = 1; predict(-1, 1); run_once("t4", 400);
    chk("lock_timeout_latency", done_cyc - rst_fall_cyc, LOCK_TIMEOUT);
    force_nolock = 0;

    // 5: extra start while busy, reset in RD_WAIT
    drop_at = 1; acc_cnt = 0; n0 = n_den;
    exp_q.push_back('{1'b0, t_a[0], 16'h0});
    @(negedge dclk) start = 1'b1;
    @(negedge dclk) start = 1'b0;
    @(negedge dclk) start = 1'b1;
    @(negedge dclk) start = 1'b0;
    chk("t5_busy", busy, 1);
    for (int k = 0; k < 50 && n_den == n0; k++) @(negedge dclk);
    chk("t5_first_den_seen", n_den - n0, 1);
    repeat (3) @(negedge dclk);
    reset_n = 1'b0; #1;
    chk_reset_vals("t5_reset");
    repeat (2) @(negedge dclk);
    reset_n = 1'b1; drop_at = -1;
    chk("t5_queue_empty", exp_q.size(), 0);
    repeat (30) @(negedge dclk);
    predict(-1, 0); run_once("t5_clean", 400);

`ifdef PLL_DRP_VERIFY_EN
    // 6: corrupted read-back
    corrupt = 1; predict(-1, 0); run_once("t6", 400);
    corrupt = 0;
    predict(-1, 0); run_once("t6_clean", 400);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
